// File: rtl/flash_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : flash_pkg
// Purpose  : Shared types and constants for the parallel NOR flash controller:
//            command op encodings, controller/bus-cycle state enums, the JEDEC
//            unlock address/data constants and a sequence-length helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package flash_pkg;

  // Host command encodings as carried on cmd_op.
  typedef enum logic [1:0] {
    OP_READ   = 2'd0,
    OP_PROG   = 2'd1,
    OP_SERASE = 2'd2,
    OP_CERASE = 2'd3
  } op_e;

  // Controller states.
  typedef enum logic [2:0] {
    RST_WAIT = 3'd0,
    IDLE     = 3'd1,
    SEQ      = 3'd2,
    POLL     = 3'd3,
    DONE     = 3'd4
  } state_e;

  // Phases of a single flash bus cycle.
  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_SETUP = 3'd1,
    PH_PULSE = 3'd2,
    PH_HOLD  = 3'd3,
    PH_GAP   = 3'd4
  } phase_e;

  // Unlock-cycle addresses and command bytes.
  localparam logic [11:0] UNLOCK_ADDR_1    = 12'h555;
  localparam logic [11:0] UNLOCK_ADDR_2    = 12'h2AA;
  localparam logic [7:0]  UNLOCK_DATA_1    = 8'hAA;
  localparam logic [7:0]  UNLOCK_DATA_2    = 8'h55;
  localparam logic [7:0]  CMD_PROGRAM      = 8'hA0;
  localparam logic [7:0]  CMD_ERASE_SETUP  = 8'h80;
  localparam logic [7:0]  CMD_SECTOR_ERASE = 8'h30;
  localparam logic [7:0]  CMD_CHIP_ERASE   = 8'h10;

  // Clocks spent in POLL before ry_by is trusted (device needs time to
  // pull ry_by low after the final command write).
  localparam logic [2:0]  POLL_DELAY       = 3'd4;

  // Number of bus cycles issued for each operation.
  function automatic logic [2:0] seq_len(input op_e op);
    case (op)
      OP_READ: return 3'd1;
      OP_PROG: return 3'd4;
      default: return 3'd6;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/flash_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : flash_if
// Purpose  : Host-side command/response bundle for flash_ctrl.
// Ports    : cmd_valid/cmd_ready handshake, cmd_op/cmd_addr/cmd_wdata command,
//            rd_valid/rd_data read return, done/err completion.
//            master = host side, slave = controller side.
// Revision : 1.0 - initial release
// ============================================================================
interface flash_if #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 16
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              done;
  logic              err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    input  cmd_ready, rd_valid, rd_data, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    output cmd_ready, rd_valid, rd_data, done, err
  );

endinterface
`default_nettype wire

// File: rtl/flash_bus_cycle.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : flash_bus_cycle
// Purpose  : Generates one asynchronous flash read or write cycle:
//            SETUP (ce_n low, addr/data stable) -> PULSE (oe_n or we_n low)
//            -> HOLD (strobes high, ce_n low) -> GAP (ce_n high, 1 clock).
// Ports    : clk, rst        - clock, synchronous active-high reset
//            start, rw       - launch request (taken only when idle), 1=write
//            addr, wdata     - cycle address and write data (captured at start)
//            dq_i            - flash read data
//            ce_n/oe_n/we_n  - registered active-low strobes
//            dq_oe, dq_o     - DQ drive enable and write data
//            bus_addr        - flash address
//            rdata           - read data captured on the last PULSE clock
//            busy            - cycle in progress
//            last            - high during the GAP clock (cycle complete)
// Revision : 1.0 - initial release
// ============================================================================
module flash_bus_cycle
  import flash_pkg::*;
#(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 16,
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 4,
  parameter int T_HOLD  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] dq_i,
  output logic              ce_n,
  output logic              oe_n,
  output logic              we_n,
  output logic              dq_oe,
  output logic [DATA_W-1:0] dq_o,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              last
);

  localparam int T_MAX0 = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
  localparam int T_MAX  = (T_MAX0 > T_HOLD) ? T_MAX0 : T_HOLD;
  localparam int CNT_W  = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [CNT_W-1:0] SETUP_END = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] PULSE_END = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] HOLD_END  = CNT_W'(T_HOLD - 1);

  phase_e           phase;
  logic [CNT_W-1:0] cnt;
  logic             write_cycle;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase       <= PH_IDLE;
      cnt         <= '0;
      write_cycle <= 1'b0;
      ce_n        <= 1'b1;
      oe_n        <= 1'b1;
      we_n        <= 1'b1;
      dq_oe       <= 1'b0;
      dq_o        <= '0;
      bus_addr    <= '0;
      rdata       <= '0;
      last        <= 1'b0;
    end else begin
      last <= 1'b0;
      case (phase)
        PH_IDLE: begin
          if (start) begin
            phase       <= PH_SETUP;
            cnt         <= '0;
            ce_n        <= 1'b0;
            bus_addr    <= addr;
            dq_o        <= wdata;
            dq_oe       <= rw;
            write_cycle <= rw;
          end
        end
        PH_SETUP: begin
          if (cnt == SETUP_END) begin
            phase <= PH_PULSE;
            cnt   <= '0;
            // Exactly one strobe goes low, chosen by cycle direction.
            we_n  <= ~write_cycle;
            oe_n  <= write_cycle;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PH_PULSE: begin
          if (cnt == PULSE_END) begin
            phase <= PH_HOLD;
            cnt   <= '0;
            we_n  <= 1'b1;
            oe_n  <= 1'b1;
            // Data is taken while oe_n is still low on the last pulse clock.
            if (!write_cycle) begin
              rdata <= dq_i;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PH_HOLD: begin
          if (cnt == HOLD_END) begin
            phase <= PH_GAP;
            cnt   <= '0;
            ce_n  <= 1'b1;
            dq_oe <= 1'b0;
            last  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PH_GAP: begin
          phase <= PH_IDLE;
        end
        default: begin
          phase <= PH_IDLE;
        end
      endcase
    end
  end

  assign busy = (phase != PH_IDLE);

endmodule
`default_nettype wire

// File: rtl/flash_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : flash_ctrl
// Purpose  : Parallel NOR flash controller. Accepts read / program / sector
//            erase / chip erase commands, issues the unlock write sequences
//            through flash_bus_cycle, polls ry_by with a saturating timeout and
//            drives the flash reset pin after power-up and after a timeout.
// Ports    : CLK50M, RST          - clock, synchronous active-high reset
//            host (flash_if.slave) - command handshake and responses
//            flash_addr, flash_dq_o, flash_dq_oe, flash_dq_i - address/data
//            flash_ce_n, flash_oe_n, flash_we_n, flash_rst_n - strobes
//            flash_ry_by           - device ready(1)/busy(0)
// Revision : 1.0 - initial release
// ============================================================================
module flash_ctrl
  import flash_pkg::*;
#(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 16,
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 4,
  parameter int T_HOLD  = 2,
  parameter int T_RST   = 100,
  parameter int TMO_W   = 24
) (
  input  logic              CLK50M,
  input  logic              RST,
  flash_if.slave            host,
  output logic [ADDR_W-1:0] flash_addr,
  output logic [DATA_W-1:0] flash_dq_o,
  output logic              flash_dq_oe,
  input  logic [DATA_W-1:0] flash_dq_i,
  input  logic              flash_ry_by,
  output logic              flash_ce_n,
  output logic              flash_oe_n,
  output logic              flash_we_n,
  output logic              flash_rst_n
);

  localparam int RST_CNT_W = (T_RST > 1) ? $clog2(T_RST) : 1;
  localparam logic [RST_CNT_W-1:0] RST_END = RST_CNT_W'(T_RST - 1);

  state_e               state;
  logic [RST_CNT_W-1:0] rst_cnt;
  logic [2:0]           step;
  logic [2:0]           poll_cnt;
  logic [TMO_W-1:0]     tmo_cnt;
  op_e                  op_lat;
  logic [ADDR_W-1:0]    addr_lat;
  logic [DATA_W-1:0]    wdata_lat;
  logic                 pending;

  logic                 cmd_ready_reg;
  logic                 rd_valid_reg;
  logic [DATA_W-1:0]    rd_data_reg;
  logic                 done_reg;
  logic                 err_reg;

  logic                 bus_start;
  logic                 bus_busy;
  logic                 bus_last;
  logic [DATA_W-1:0]    bus_rdata;
  logic [ADDR_W-1:0]    seq_addr;
  logic [DATA_W-1:0]    seq_data;
  logic                 seq_rw;

  // Address/data/direction for the current step of the latched command.
  always_comb begin
    seq_addr = addr_lat;
    seq_data = wdata_lat;
    seq_rw   = 1'b1;
    case (op_lat)
      OP_READ: begin
        seq_rw = 1'b0;
      end
      OP_PROG: begin
        case (step)
          3'd0:    begin seq_addr = ADDR_W'(UNLOCK_ADDR_1); seq_data = DATA_W'(UNLOCK_DATA_1); end
          3'd1:    begin seq_addr = ADDR_W'(UNLOCK_ADDR_2); seq_data = DATA_W'(UNLOCK_DATA_2); end
          3'd2:    begin seq_addr = ADDR_W'(UNLOCK_ADDR_1); seq_data = DATA_W'(CMD_PROGRAM);   end
          default: begin seq_addr = addr_lat;               seq_data = wdata_lat;              end
        endcase
      end
      default: begin
        case (step)
          3'd0:    begin seq_addr = ADDR_W'(UNLOCK_ADDR_1); seq_data = DATA_W'(UNLOCK_DATA_1);   end
          3'd1:    begin seq_addr = ADDR_W'(UNLOCK_ADDR_2); seq_data = DATA_W'(UNLOCK_DATA_2);   end
          3'd2:    begin seq_addr = ADDR_W'(UNLOCK_ADDR_1); seq_data = DATA_W'(CMD_ERASE_SETUP); end
          3'd3:    begin seq_addr = ADDR_W'(UNLOCK_ADDR_1); seq_data = DATA_W'(UNLOCK_DATA_1);   end
          3'd4:    begin seq_addr = ADDR_W'(UNLOCK_ADDR_2); seq_data = DATA_W'(UNLOCK_DATA_2);   end
          default: begin
            if (op_lat == OP_CERASE) begin
              seq_addr = ADDR_W'(UNLOCK_ADDR_1);
              seq_data = DATA_W'(CMD_CHIP_ERASE);
            end else begin
              seq_addr = addr_lat;
              seq_data = DATA_W'(CMD_SECTOR_ERASE);
            end
          end
        endcase
      end
    endcase
  end

  // A pending step launches as soon as the bus engine is idle.
  assign bus_start = pending && !bus_busy;

  always_ff @(posedge CLK50M) begin
    if (RST) begin
      state         <= RST_WAIT;
      rst_cnt       <= '0;
      step          <= '0;
      poll_cnt      <= '0;
      tmo_cnt       <= '0;
      op_lat        <= OP_READ;
      addr_lat      <= '0;
      wdata_lat     <= '0;
      pending       <= 1'b0;
      flash_rst_n   <= 1'b0;
      cmd_ready_reg <= 1'b0;
      rd_valid_reg  <= 1'b0;
      rd_data_reg   <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      rd_valid_reg <= 1'b0;
      done_reg     <= 1'b0;
      if (bus_start) begin
        pending <= 1'b0;
      end
      case (state)
        RST_WAIT: begin
          if (rst_cnt == RST_END) begin
            rst_cnt       <= '0;
            flash_rst_n   <= 1'b1;
            cmd_ready_reg <= 1'b1;
            state         <= IDLE;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (host.cmd_valid && cmd_ready_reg) begin
            op_lat        <= op_e'(host.cmd_op);
            addr_lat      <= host.cmd_addr;
            wdata_lat     <= host.cmd_wdata;
            step          <= '0;
            pending       <= 1'b1;
            cmd_ready_reg <= 1'b0;
            state         <= SEQ;
          end
        end
        SEQ: begin
          if (bus_last) begin
            if (step == seq_len(op_lat) - 3'd1) begin
              if (op_lat == OP_READ) begin
                rd_valid_reg <= 1'b1;
                rd_data_reg  <= bus_rdata;
                done_reg     <= 1'b1;
                err_reg      <= 1'b0;
                state        <= DONE;
              end else begin
                poll_cnt <= '0;
                tmo_cnt  <= '0;
                state    <= POLL;
              end
            end else begin
              step    <= step + 3'd1;
              pending <= 1'b1;
            end
          end
        end
        POLL: begin
          if ((poll_cnt == POLL_DELAY) && flash_ry_by) begin
            done_reg <= 1'b1;
            err_reg  <= 1'b0;
            state    <= DONE;
          end else if (&tmo_cnt) begin
            done_reg <= 1'b1;
            err_reg  <= 1'b1;
            state    <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (poll_cnt != POLL_DELAY) begin
              poll_cnt <= poll_cnt + 3'd1;
            end
          end
        end
        DONE: begin
          err_reg <= 1'b0;
          // A timed-out device is reset before new commands are accepted.
          if (err_reg) begin
            flash_rst_n <= 1'b0;
            rst_cnt     <= '0;
            state       <= RST_WAIT;
          end else begin
            cmd_ready_reg <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state <= RST_WAIT;
        end
      endcase
    end
  end

  assign host.cmd_ready = cmd_ready_reg;
  assign host.rd_valid  = rd_valid_reg;
  assign host.rd_data   = rd_data_reg;
  assign host.done      = done_reg;
  assign host.err       = err_reg;

  flash_bus_cycle #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .T_SETUP (T_SETUP),
    .T_PULSE (T_PULSE),
    .T_HOLD  (T_HOLD)
  ) u_bus_cycle (
    .clk      (CLK50M),
    .rst      (RST),
    .start    (bus_start),
    .rw       (seq_rw),
    .addr     (seq_addr),
    .wdata    (seq_data),
    .dq_i     (flash_dq_i),
    .ce_n     (flash_ce_n),
    .oe_n     (flash_oe_n),
    .we_n     (flash_we_n),
    .dq_oe    (flash_dq_oe),
    .dq_o     (flash_dq_o),
    .bus_addr (flash_addr),
    .rdata    (bus_rdata),
    .busy     (bus_busy),
    .last     (bus_last)
  );

endmodule
`default_nettype wire

// File: tb/tb_flash_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_flash_ctrl
// Purpose  : Directed self-checking bench for flash_ctrl with a small flash
//            model (read data, write log, ry_by busy timer) and a strobe
//            exclusivity monitor.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_flash_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [21:0] flash_addr;
  logic [15:0] flash_dq_o;
  logic        flash_dq_oe;
  logic [15:0] flash_dq_i;
  logic        flash_ry_by = 1'b1;
  logic        flash_ce_n;
  logic        flash_oe_n;
  logic        flash_we_n;
  logic        flash_rst_n;

  flash_if #(.ADDR_W(22), .DATA_W(16)) bus ();

  flash_ctrl #(
    .ADDR_W(22), .DATA_W(16), .T_SETUP(2), .T_PULSE(4), .T_HOLD(2),
    .T_RST(100), .TMO_W(8)
  ) dut (
    .CLK50M      (clk),
    .RST         (rst),
    .host        (bus),
    .flash_addr  (flash_addr),
    .flash_dq_o  (flash_dq_o),
    .flash_dq_oe (flash_dq_oe),
    .flash_dq_i  (flash_dq_i),
    .flash_ry_by (flash_ry_by),
    .flash_ce_n  (flash_ce_n),
    .flash_oe_n  (flash_oe_n),
    .flash_we_n  (flash_we_n),
    .flash_rst_n (flash_rst_n)
  );

  always #10 clk = ~clk;

  // ---------------- flash model and monitors ----------------
  logic [15:0] mem_word = 16'hBEEF;
  assign flash_dq_i = (!flash_ce_n && !flash_oe_n) ? mem_word : 16'h0000;

  int          cyc = 0;
  int          wr_count = 0, wf_count = 0, busy_trigger = 0, busy_left = 0, busy_len = 0;
  int          oe_low = 0, we_low = 0, viol = 0, done_count = 0, ry_rise_cyc = 0;
  logic        prev_we = 1'b1;
  logic [21:0] wr_a [16];
  logic [15:0] wr_d [16];
  logic [21:0] rd_addr_seen = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!prev_we && flash_we_n) begin
      wr_a[wr_count % 16] = flash_addr;
      wr_d[wr_count % 16] = flash_dq_o;
      wr_count++;
      if (wr_count == busy_trigger) busy_left = busy_len;
    end
    if (prev_we && !flash_we_n) wf_count++;
    prev_we = flash_we_n;
    if (busy_left > 0) begin
      flash_ry_by = 1'b0;
      busy_left--;
    end else if (!flash_ry_by) begin
      flash_ry_by = 1'b1;
      ry_rise_cyc = cyc;
    end
    if (!flash_oe_n) begin oe_low++; rd_addr_seen = flash_addr; end
    if (!flash_we_n) we_low++;
    if (!flash_oe_n && !flash_we_n) viol++;
    if (flash_dq_oe && !flash_oe_n) viol++;
    if (bus.done) done_count++;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  logic        got_rd_valid, got_err;
  logic [15:0] got_rd_data;
  int          done_cyc;

  task automatic send_cmd(input logic [1:0] op, input logic [21:0] a, input logic [15:0] d);
    int i = 0;
    @(negedge clk);
    while (!bus.cmd_ready && i < 500) begin @(negedge clk); i++; end
    check("cmd_ready_wait", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = a; bus.cmd_wdata = d;
    @(posedge clk); #1;
    // Scramble the command fields to prove they were latched.
    bus.cmd_valid = 1'b0; bus.cmd_op = ~op; bus.cmd_addr = '1; bus.cmd_wdata = '1;
  endtask

  task automatic wait_done(input int bound);
    logic seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        got_rd_valid = bus.rd_valid; got_rd_data = bus.rd_data; got_err = bus.err;
        done_cyc = cyc;
      end
    end
    check("done_seen", seen, 1);
  endtask

  task automatic measure_rst_low(output int n);
    n = 0;
    @(negedge clk);
    while (!flash_rst_n && n < 1000) begin n++; @(negedge clk); end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_low, snap;

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_addr = '0; bus.cmd_wdata = '0;

    // Reset state and flash reset low-time
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_ce_n", flash_ce_n, 1);
    check("rst_oe_n", flash_oe_n, 1);
    check("rst_we_n", flash_we_n, 1);
    check("rst_flash_rst_n", flash_rst_n, 0);
    check("rst_dq_oe", flash_dq_oe, 0);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_done_err", {bus.done, bus.err, bus.rd_valid}, 0);
    check("rst_addr", flash_addr, 0);
    @(posedge clk); #1 rst = 1'b0;
    measure_rst_low(n_low);
    check("por_rst_low_clocks", n_low, 100);
    check("por_cmd_ready", bus.cmd_ready, 1);

    // Read 0x12345 -> 0xBEEF
    oe_low = 0; we_low = 0; mem_word = 16'hBEEF;
    send_cmd(2'd0, 22'h012345, 16'h0000);
    wait_done(200);
    check("rd_valid", got_rd_valid, 1);
    check("rd_data", got_rd_data, 16'hBEEF);
    check("rd_err", got_err, 0);
    check("rd_oe_low_clocks", oe_low, 4);
    check("rd_we_low_clocks", we_low, 0);
    check("rd_addr_latched", rd_addr_seen, 22'h012345);
    @(negedge clk);
    check("done_one_cycle", bus.done, 0);
    check("b2b_cmd_ready", bus.cmd_ready, 1);

    // Back-to-back read at address 0
    mem_word = 16'h1234;
    send_cmd(2'd0, 22'h000000, 16'h0000);
    wait_done(200);
    check("rd2_data", got_rd_data, 16'h1234);
    check("rd2_addr", rd_addr_seen, 22'h000000);

    // Program 0x000100 / 0x5A5A, busy 50 clocks
    wr_count = 0; we_low = 0; busy_trigger = 4; busy_len = 50;
    send_cmd(2'd1, 22'h000100, 16'h5A5A);
    wait_done(500);
    check("prog_err", got_err, 0);
    check("prog_rd_valid", got_rd_valid, 0);
    check("prog_done_after_ready", done_cyc - ry_rise_cyc, 1);
    check("prog_wr_count", wr_count, 4);
    check("prog_we_low_clocks", we_low, 16);
    check("prog_w0", {wr_a[0], wr_d[0]}, {22'h555, 16'h00AA});
    check("prog_w1", {wr_a[1], wr_d[1]}, {22'h2AA, 16'h0055});
    check("prog_w2", {wr_a[2], wr_d[2]}, {22'h555, 16'h00A0});
    check("prog_w3", {wr_a[3], wr_d[3]}, {22'h100, 16'h5A5A});

    // Chip erase, busy 10 clocks
    wr_count = 0; busy_trigger = 6; busy_len = 10;
    send_cmd(2'd3, 22'h000000, 16'h0000);
    wait_done(500);
    check("cerase_err", got_err, 0);
    check("cerase_wr_count", wr_count, 6);
    check("cerase_w2", {wr_a[2], wr_d[2]}, {22'h555, 16'h0080});
    check("cerase_w3", {wr_a[3], wr_d[3]}, {22'h555, 16'h00AA});
    check("cerase_w5", {wr_a[5], wr_d[5]}, {22'h555, 16'h0010});

    // Sector erase with ry_by stuck low -> timeout
    wr_count = 0; busy_trigger = 6; busy_len = 1000000;
    send_cmd(2'd2, 22'h0A0000, 16'hFFFF);
    wait_done(2000);
    check("tmo_err", got_err, 1);
    check("tmo_wr_count", wr_count, 6);
    check("tmo_w4", {wr_a[4], wr_d[4]}, {22'h2AA, 16'h0055});
    check("tmo_w5", {wr_a[5], wr_d[5]}, {22'h0A0000, 16'h0030});
    measure_rst_low(n_low);
    check("tmo_rst_low_clocks", n_low, 100);
    check("tmo_cmd_ready", bus.cmd_ready, 1);
    busy_left = 0;
    repeat (2) @(negedge clk);

    // RST during the third erase write
    busy_trigger = 0; wf_count = 0; snap = done_count;
    send_cmd(2'd2, 22'h001000, 16'h0000);
    for (int i = 0; i < 500 && wf_count < 3; i++) @(negedge clk);
    check("abort_reached_w3", wf_count, 3);
    check("abort_we_low_before", flash_we_n, 0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_strobes", {flash_ce_n, flash_oe_n, flash_we_n}, 3'b111);
    check("abort_dq_oe", flash_dq_oe, 0);
    check("abort_flash_rst_n", flash_rst_n, 0);
    check("abort_cmd_ready", bus.cmd_ready, 0);
    repeat (3) @(negedge clk);
    check("abort_no_done", done_count, snap);
    @(posedge clk); #1 rst = 1'b0;
    measure_rst_low(n_low);
    check("abort_rst_low_clocks", n_low, 100);
    check("abort_cmd_ready", bus.cmd_ready, 1);

    check("strobe_violations", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/flash_ctrl.md
FLASH_CTRL -- requirements
Module: flash_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 22, flash word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, flash data width.
REQ-003 SHALL have parameters T_SETUP=2, T_PULSE=4, T_HOLD=2, each ≥1, giving the clock counts of bus-cycle phases.
REQ-004 SHALL have parameter T_RST, default 100, giving the flash_rst_n low-time in clocks after reset release.
REQ-005 SHALL have parameter TMO_W, default 24, giving the busy-timeout counter width; timeout is reached at all-ones.
REQ-006 CLK50M  in  1  sole clock; all logic on rising edge.
REQ-007 RST  in  1  synchronous, active-high reset.
REQ-008 cmd_valid/cmd_ready  in/out  1/1  command handshake; transfer when both are high.
REQ-009 cmd_op  in  2  0=read, 1=program, 2=sector erase, 3=chip erase.
REQ-010 cmd_addr/cmd_wdata  in  ADDR_W/DATA_W  target address and program data.
REQ-011 rd_valid/rd_data  out  1/DATA_W  one-cycle read-data strobe and data.
REQ-012 done/err  out  1/1  one-cycle completion pulse; err is valid with done (timeout).
REQ-013 flash_addr/flash_dq_o/flash_dq_oe  out  ADDR_W/DATA_W/1  address, write data and DQ drive enable.
REQ-014 flash_dq_i/flash_ry_by  in  DATA_W/1  read data and ready(1)/busy(0).
REQ-015 flash_ce_n/flash_oe_n/flash_we_n/flash_rst_n  out  1 each  active-low flash controls.

Function
REQ-016 FSM states SHALL be RST_WAIT, IDLE, SEQ, POLL, DONE.
REQ-017 RST_WAIT SHALL hold flash_rst_n=0 for T_RST clocks, then drive it 1 and go to IDLE.
REQ-018 cmd_ready SHALL be 1 only in IDLE.
REQ-019 Each bus cycle SHALL be: SETUP (ce_n=0, address/data stable, T_SETUP clocks), PULSE (we_n=0 for a write or oe_n=0 for a read, T_PULSE clocks), HOLD (strobes 1, ce_n=0, T_HOLD clocks), then ce_n=1 for 1 clock.
REQ-020 oe_n and we_n SHALL never be low at the same time; flash_dq_oe SHALL be 1 only during write cycles.
REQ-021 A read SHALL be one read cycle; rd_data SHALL be sampled from flash_dq_i on the last PULSE clock; rd_valid and done SHALL pulse together on the clock after ce_n returns to 1.
REQ-022 A program SHALL issue writes 0x555/0xAA, 0x2AA/0x55, 0x555/0xA0, then cmd_addr/cmd_wdata, and then enter POLL.
REQ-023 A sector erase SHALL issue writes 0x555/AA, 2AA/55, 555/80, 555/AA, 2AA/55, then cmd_addr/0x30, and then enter POLL; a chip erase SHALL issue the same sequence with 0x555/0x10 as the last write.
REQ-024 Command data SHALL be zero-extended to DATA_W, and sequence addresses zero-extended to ADDR_W.
REQ-025 POLL SHALL wait 4 clocks and then sample flash_ry_by each clock; ry_by=1 SHALL go to DONE with err=0.
REQ-026 If the timeout counter saturates in POLL, the block SHALL go to DONE with err=1, and flash_rst_n SHALL be pulsed low for T_RST clocks before IDLE.
REQ-027 DONE SHALL last 1 clock and return to IDLE; back-to-back commands SHALL be accepted on the next clock.
REQ-028 cmd_* inputs SHALL be latched at acceptance; later changes SHALL have no effect.

Reset
REQ-029 While RST=1: ce_n/oe_n/we_n=1, flash_rst_n=0, dq_oe=0, cmd_ready=0, rd_valid=done=err=0, flash_addr=0, and the state is RST_WAIT with its counter cleared.
REQ-030 RST asserted mid-cycle SHALL abort the operation, with all strobes high on the next clock and no done pulse.

Structure
REQ-031 The package flash_pkg SHALL hold the op encodings, FSM state enum and unlock address/data constants.
REQ-032 The sub-module flash_bus_cycle SHALL implement REQ-019/020 (start, rw, addr, wdata → strobes, rdata, busy, last).

Verification
REQ-033 Reset: release RST → flash_rst_n low exactly 100 clocks; cmd_ready rises on the following clock.
REQ-034 Read addr 0x12345 with model data 0xBEEF → oe_n low 4 clocks, rd_data=0xBEEF with rd_valid and done, err=0.
REQ-035 Program 0x000100/0x5A5A with ry_by low 50 clocks → four we_n pulses in the correct order, done after ry_by rises, err=0.
REQ-036 Sector erase with ry_by stuck low, TMO_W=8 → done with err=1 and a flash_rst_n pulse, then cmd_ready.
REQ-037 RST raised during the 3rd erase write → strobes high next clock, no done, RST_WAIT re-entered.
REQ-038 Checker on all tests: oe_n and we_n never both low; dq_oe never 1 while oe_n=0.
